nonce_sweep_ctrl: RTL



---
 rtl/sha_ctrl_pkg.sv | 20 ++
 rtl/nonce_sweep_ctrl_if.sv | 23 ++
 rtl/nonce_hit_select.sv | 66 ++++++
 rtl/nonce_sweep_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sha_ctrl_pkg.sv
// Shared types and helpers for the nonce sweep controller.
// Nonce arithmetic is done in 33 bits so range-end checks see 32-bit wrap.
package sha_ctrl_pkg;

   localparam int unsigned NoncesPerBatchDef = 16;

   typedef enum logic [2:0] {
      StIdle,
      StLaunch,
      StWaitAck,
      StRun,
      StEval,
      StDrain
   } state_e;

   function automatic logic [32:0] nonce_add(input logic [31:0] a, input logic [31:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/nonce_sweep_ctrl_if.sv
// Launch/result port between the sweep controller (master) and the hash core (slave).
interface nonce_sweep_ctrl_if
   import sha_ctrl_pkg::*;
#(
   parameter int unsigned IDX_W = $clog2(NoncesPerBatchDef)
);
   logic             core_start;
   logic [31:0]      core_nonce_base;
   logic             core_done;
   logic             res_valid;
   logic [IDX_W-1:0] res_idx;
   logic [31:0]      res_h0;

   modport master (
      output core_start, core_nonce_base,
      input  core_done, res_valid, res_idx, res_h0
   );

   modport slave (
      input  core_start, core_nonce_base,
      output core_done, res_valid, res_idx, res_h0
   );
endinterface

// File: rtl/nonce_hit_select.sv
// Tracks which result slots have reported in a batch and the lowest-index hit with its h0.
// Per-slot h0 is kept so a later overwrite of the current lowest hit exposes the next one.
module nonce_hit_select #(
   parameter int unsigned NumSlots = 16,
   parameter int unsigned IdxW     = $clog2(NumSlots)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clear_i,
   input  logic            res_valid_i,
   input  logic [IdxW-1:0] res_idx_i,
   input  logic [31:0]     res_h0_i,
   input  logic            is_hit_i,
   output logic            all_seen_o,
   output logic            hit_o,
   output logic [IdxW-1:0] hit_idx_o,
   output logic [31:0]     hit_h0_o
);

   logic [NumSlots-1:0] seen_q, seen_d;
   logic [NumSlots-1:0] hitv_q, hitv_d;
   logic [NumSlots-1:0] strobe;
   logic [31:0]         h0_q [NumSlots];

   always_comb begin
      strobe = '0;
      if (res_valid_i) strobe[res_idx_i] = 1'b1;
      seen_d = seen_q;
      hitv_d = hitv_q;
      if (clear_i) begin
         seen_d = '0;
         hitv_d = '0;
      end else if (res_valid_i) begin
         seen_d[res_idx_i] = 1'b1;
         hitv_d[res_idx_i] = is_hit_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seen_q <= '0;
         hitv_q <= '0;
         for (int i = 0; i < int'(NumSlots); i++) h0_q[i] <= '0;
      end else begin
         seen_q <= seen_d;
         hitv_q <= hitv_d;
         if (!clear_i && res_valid_i && is_hit_i) h0_q[res_idx_i] <= res_h0_i;
      end
   end

   // A strobe in the same cycle as the core's completion still counts.
   assign all_seen_o = &(seen_q | strobe);
   assign hit_o      = |hitv_q;

   always_comb begin
      hit_idx_o = '0;
      hit_h0_o  = '0;
      for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
         if (hitv_q[i]) begin
            hit_idx_o = IdxW'(i);
            hit_h0_o  = h0_q[i];
         end
      end
   end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Sweeps a nonce range through the multi-nonce hash core one batch at a time and
// stops on the lowest nonce whose final h0 is below the target.
module nonce_sweep_ctrl
   import sha_ctrl_pkg::*;
#(
   parameter int unsigned NONCES_PER_BATCH = NoncesPerBatchDef,
   parameter int unsigned IDX_W            = $clog2(NONCES_PER_BATCH),
   parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [31:0]               cfg_nonce_first,
   input  logic [31:0]               cfg_nonce_last,
   input  logic [31:0]               cfg_target,
   output logic                      done,
   output logic                      found,
   output logic [31:0]               found_nonce,
   output logic [31:0]               found_h0,
   output logic                      err,
   output logic                      aborted,
   output logic [31:0]               batch_count,
   nonce_sweep_ctrl_if.master        core
);

   state_e      state_q, state_d;
   logic [31:0] base_q, base_d;
   logic [31:0] last_q, last_d;
   logic [31:0] target_q, target_d;
   logic        found_q, found_d;
   logic [31:0] found_nonce_q, found_nonce_d;
   logic [31:0] found_h0_q, found_h0_d;
   logic        err_q, err_d;
   logic        aborted_q, aborted_d;
   logic [31:0] batch_q, batch_d;
   logic [31:0] tmo_q, tmo_d;

   logic             hs_clear;
   logic             hs_valid;
   logic             hs_is_hit;
   logic             hs_all_seen;
   logic             hs_hit;
   logic [IDX_W-1:0] hs_hit_idx;
   logic [31:0]      hs_hit_h0;
   logic             tmo_expired;
   logic             range_end;

   assign hs_valid    = core.res_valid && (state_q == StRun);
   assign hs_is_hit   = (core.res_h0 < target_q) &&
                        (nonce_add(base_q, 32'(core.res_idx)) <= {1'b0, last_q});
   assign tmo_expired = (tmo_q == 32'(TIMEOUT_CYCLES - 1));
   assign range_end   = nonce_add(base_q, 32'(NONCES_PER_BATCH)) > {1'b0, last_q};

   nonce_hit_select #(
      .NumSlots (NONCES_PER_BATCH),
      .IdxW     (IDX_W)
   ) u_hit_select (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .clear_i     (hs_clear),
      .res_valid_i (hs_valid),
      .res_idx_i   (core.res_idx),
      .res_h0_i    (core.res_h0),
      .is_hit_i    (hs_is_hit),
      .all_seen_o  (hs_all_seen),
      .hit_o       (hs_hit),
      .hit_idx_o   (hs_hit_idx),
      .hit_h0_o    (hs_hit_h0)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         base_q        <= '0;
         last_q        <= '0;
         target_q      <= '0;
         found_q       <= 1'b0;
         found_nonce_q <= '0;
         found_h0_q    <= '0;
         err_q         <= 1'b0;
         aborted_q     <= 1'b0;
         batch_q       <= '0;
         tmo_q         <= '0;
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         last_q        <= last_d;
         target_q      <= target_d;
         found_q       <= found_d;
         found_nonce_q <= found_nonce_d;
         found_h0_q    <= found_h0_d;
         err_q         <= err_d;
         aborted_q     <= aborted_d;
         batch_q       <= batch_d;
         tmo_q         <= tmo_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      last_d        = last_q;
      target_d      = target_q;
      found_d       = found_q;
      found_nonce_d = found_nonce_q;
      found_h0_d    = found_h0_q;
      err_d         = err_q;
      aborted_d     = aborted_q;
      batch_d       = batch_q;
      tmo_d         = tmo_q;
      hs_clear      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               base_d        = cfg_nonce_first;
               last_d        = cfg_nonce_last;
               target_d      = cfg_target;
               found_d       = 1'b0;
               found_nonce_d = '0;
               found_h0_d    = '0;
               err_d         = 1'b0;
               aborted_d     = 1'b0;
               batch_d       = '0;
               if (cfg_nonce_last >= cfg_nonce_first) state_d = StLaunch;
            end
         end
         StLaunch: begin
            hs_clear = 1'b1;
            tmo_d    = '0;
            batch_d  = batch_q + 32'd1;
            state_d  = StWaitAck;
         end
         StWaitAck, StRun: begin
            tmo_d = tmo_q + 32'd1;
            if (tmo_expired) begin
               err_d   = 1'b1;
               state_d = core.core_done ? StIdle : StDrain;
            end else if (abort) begin
               aborted_d = 1'b1;
               state_d   = StDrain;
            end else if (state_q == StWaitAck) begin
               if (!core.core_done) state_d = StRun;
            end else if (core.core_done) begin
               if (hs_all_seen) begin
                  state_d = StEval;
               end else begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         StEval: begin
            if (hs_hit) begin
               found_d       = 1'b1;
               found_nonce_d = base_q + 32'(hs_hit_idx);
               found_h0_d    = hs_hit_h0;
               state_d       = StIdle;
            end else if (range_end) begin
               state_d = StIdle;
            end else if (abort) begin
               aborted_d = 1'b1;
               state_d   = StIdle;
            end else begin
               base_d  = base_q + 32'(NONCES_PER_BATCH);
               state_d = StLaunch;
            end
         end
         StDrain: begin
            if (core.core_done) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      done                 = (state_q == StIdle);
      core.core_start      = (state_q == StLaunch);
      core.core_nonce_base = base_q;
      found                = found_q;
      found_nonce          = found_nonce_q;
      found_h0             = found_h0_q;
      err                  = err_q;
      aborted              = aborted_q;
      batch_count          = batch_q;
   end

endmodule
